eth_rst_seq: RTL
================

ETH_RST_SEQ -- requirements
Module: eth_rst_seq

Interface
REQ-001 SHALL have parameter C_HOLD_CYCLES, default 32, cycles all resets are held asserted before release (1..65535).
REQ-002 SHALL have parameter C_LOCK_TIMEOUT, default 65535, cycles allowed for PHY lock after phy_reset release (1..65535).
REQ-003 SHALL have parameter C_STAGGER, default 16, cycles between mac_reset release and dma_reset release (1..65535).
REQ-004 SHALL have parameter C_MAX_RETRY, default 3, lock attempts before declaring failure (1..15).
REQ-005 SHALL have parameter C_DRAIN_TIMEOUT, default 1024, maximum cycles waiting for dma_idle before a soft reset (1..65535).
REQ-006 SHALL have port mm2s_clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port sys_rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port soft_reset_req, input, 1, single-cycle register-write pulse requesting a full reset sequence.
REQ-009 SHALL have port phy_ready, input, 1, PCS block-lock status, asynchronous to mm2s_clk.
REQ-010 SHALL have port dma_idle, input, 1, high when MM2S/S2MM engines have no transfer outstanding.
REQ-011 SHALL have ports phy_reset, mac_reset, dma_reset, output, 1 each, active-high registered resets.
REQ-012 SHALL have port rst_done, output, 1, high only in RUN.
REQ-013 SHALL have port rst_fail, output, 1, high only in FAIL.
REQ-014 SHALL have port retry_cnt, output, 4, failed lock attempts in the current sequence.

Function
REQ-015 SHALL implement states ASSERT, PHY_WAIT, MAC_WAIT, RUN, FAIL, plus DRAIN when configured, with one 16-bit cycle counter cleared on every state change.
REQ-016 SHALL, in ASSERT, hold all three resets high and move to PHY_WAIT when counter reaches C_HOLD_CYCLES-1.
REQ-017 SHALL, in PHY_WAIT, drive phy_reset low only; go to MAC_WAIT when synchronised phy_ready is 1; on counter reaching C_LOCK_TIMEOUT-1 without lock, go to FAIL if retry_cnt equals C_MAX_RETRY-1 (retry_cnt then incremented to C_MAX_RETRY), else increment retry_cnt and go to ASSERT.
REQ-018 SHALL give lock priority when lock and timeout coincide in the same cycle.
REQ-019 SHALL, in MAC_WAIT, drive phy_reset and mac_reset low and go to RUN when counter reaches C_STAGGER-1; loss of lock here returns to ASSERT.
REQ-020 SHALL, in RUN, drive all resets low and rst_done high; loss of synchronised phy_ready goes to ASSERT with retry_cnt cleared.
REQ-021 SHALL, on soft_reset_req in RUN, go to DRAIN (configured) or ASSERT; in any other state restart at ASSERT with counter, retry_cnt and rst_fail cleared.
REQ-022 SHALL, in FAIL, hold all resets high until soft_reset_req or sys_rst.
REQ-023 SHALL register all outputs as a decode of next state, so outputs change on the same edge as the state register.
REQ-024 SHALL synchronise phy_ready through two flops; added detection latency exactly 2 cycles.

Reset
REQ-025 SHALL, on sys_rst, set state ASSERT, counter 0, retry_cnt 0, phy_reset/mac_reset/dma_reset 1, rst_done 0, rst_fail 0, synchroniser flops 0; sys_rst overrides soft_reset_req.

Configuration
REQ-026 SHALL, with ETH_RST_DRAIN_EN defined, include DRAIN: all resets low, rst_done 0; exit to ASSERT when dma_idle is 1 or counter reaches C_DRAIN_TIMEOUT-1; loss of lock also exits to ASSERT.
REQ-027 SHALL, without ETH_RST_DRAIN_EN, omit DRAIN and its logic; soft_reset_req in RUN enters ASSERT next edge.

Structure
REQ-028 SHALL place state encodings and default parameter constants in shared package eth_rst_pkg.
REQ-029 SHALL implement the two-flop synchroniser as sub-module eth_rst_sync.

Verification (C_HOLD_CYCLES=4, C_LOCK_TIMEOUT=10, C_STAGGER=3, C_MAX_RETRY=2, C_DRAIN_TIMEOUT=8; cycle 1 = first edge with sys_rst low)
REQ-030 SHALL cover: phy_ready stuck 1 -> phy_reset falls cycle 4, mac_reset cycle 5, dma_reset and rst_done cycle 8.
REQ-031 SHALL cover: phy_ready stuck 0 -> two 10-cycle PHY_WAIT windows separated by 4 reset cycles, then rst_fail=1, retry_cnt=2, all resets high; soft_reset_req clears to a fresh sequence.
REQ-032 SHALL cover: in RUN drop phy_ready for 3 cycles -> 2 cycles later all resets high, rst_done 0, retry_cnt 0, normal re-sequence after lock returns.
REQ-033 SHALL cover: ETH_RST_DRAIN_EN, soft_reset_req in RUN with dma_idle 0 -> resets stay low 8 cycles then assert; repeat with dma_idle rising after 3 cycles -> resets assert on edge after dma_idle sampled 1.
REQ-034 SHALL cover: phy_ready rising on the cycle the synchronised value meets timeout -> MAC_WAIT entered, retry_cnt unchanged; soft_reset_req coincident with sys_rst -> reset values only.

Source files
------------

// File: rtl/eth_rst_pkg.sv
// rtl/eth_rst_pkg.sv - shared state encodings, default constants and output decode for eth_rst_seq
package eth_rst_pkg;

    localparam int DEF_HOLD_CYCLES   = 32;
    localparam int DEF_LOCK_TIMEOUT  = 65535;
    localparam int DEF_STAGGER       = 16;
    localparam int DEF_MAX_RETRY     = 3;
    localparam int DEF_DRAIN_TIMEOUT = 1024;
    localparam int CNT_W             = 16;
    localparam int RETRY_W           = 4;

    typedef enum logic [2:0] {
        ST_ASSERT   = 3'd0,
        ST_PHY_WAIT = 3'd1,
        ST_MAC_WAIT = 3'd2,
        ST_RUN      = 3'd3,
        ST_FAIL     = 3'd4
`ifdef ETH_RST_DRAIN_EN
        ,
        ST_DRAIN    = 3'd5
`endif
    } rst_state_t;

    typedef struct packed {
        logic phy;
        logic mac;
        logic dma;
        logic done;
        logic fail;
    } rst_out_t;

    localparam rst_out_t RESET_OUT = '{phy: 1'b1, mac: 1'b1, dma: 1'b1, done: 1'b0, fail: 1'b0};

    function automatic rst_out_t decode_outputs(input rst_state_t st);
        rst_out_t o;
        o = RESET_OUT;
        case (st)
            ST_PHY_WAIT: o = '{phy: 1'b0, mac: 1'b1, dma: 1'b1, done: 1'b0, fail: 1'b0};
            ST_MAC_WAIT: o = '{phy: 1'b0, mac: 1'b0, dma: 1'b1, done: 1'b0, fail: 1'b0};
            ST_RUN:      o = '{phy: 1'b0, mac: 1'b0, dma: 1'b0, done: 1'b1, fail: 1'b0};
            ST_FAIL:     o = '{phy: 1'b1, mac: 1'b1, dma: 1'b1, done: 1'b0, fail: 1'b1};
`ifdef ETH_RST_DRAIN_EN
            ST_DRAIN:    o = '{phy: 1'b0, mac: 1'b0, dma: 1'b0, done: 1'b0, fail: 1'b0};
`endif
            default:     o = RESET_OUT;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/eth_rst_seq_if.sv
// rtl/eth_rst_seq_if.sv - request/status and reset-output bundle for eth_rst_seq
interface eth_rst_seq_if;
    import eth_rst_pkg::*;

    logic               soft_reset_req;
    logic               phy_ready;
    logic               dma_idle;
    logic               phy_reset;
    logic               mac_reset;
    logic               dma_reset;
    logic               rst_done;
    logic               rst_fail;
    logic [RETRY_W-1:0] retry_cnt;

    modport master (
        output soft_reset_req, phy_ready, dma_idle,
        input  phy_reset, mac_reset, dma_reset, rst_done, rst_fail, retry_cnt
    );

    modport slave (
        input  soft_reset_req, phy_ready, dma_idle,
        output phy_reset, mac_reset, dma_reset, rst_done, rst_fail, retry_cnt
    );

endinterface

// File: rtl/eth_rst_sync.sv
// rtl/eth_rst_sync.sv - two-flop synchroniser for the asynchronous PCS lock status
module eth_rst_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/eth_rst_seq.sv
// rtl/eth_rst_seq.sv - PHY/MAC/DMA reset sequencer with lock retry; ETH_RST_DRAIN_EN adds a DMA drain phase
module eth_rst_seq
    import eth_rst_pkg::*;
#(
    parameter int C_HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int C_LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int C_STAGGER       = DEF_STAGGER,
    parameter int C_MAX_RETRY     = DEF_MAX_RETRY,
    parameter int C_DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
    input  logic         mm2s_clk,
    input  logic         sys_rst,
    eth_rst_seq_if.slave bus
);

    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(C_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST  = CNT_W'(C_LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STAG_LAST  = CNT_W'(C_STAGGER - 1);
    localparam logic [CNT_W-1:0]   DRAIN_LAST = CNT_W'(C_DRAIN_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(C_MAX_RETRY - 1);

    rst_state_t         state_q;
    rst_state_t         state_nx;
    logic [CNT_W-1:0]   cnt_q;
    logic               cnt_clr;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_nx;
    rst_out_t           out_q;
    logic               phy_lock;
    logic               restart;

    eth_rst_sync u_sync (
        .clk (mm2s_clk),
        .rst (sys_rst),
        .d   (bus.phy_ready),
        .q   (phy_lock)
    );

    always_ff @(posedge mm2s_clk) begin
        if (sys_rst) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            retry_q <= '0;
            out_q   <= RESET_OUT;
        end else begin
            state_q <= state_nx;
            retry_q <= retry_nx;
            out_q   <= decode_outputs(state_nx);
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx = state_q;
        retry_nx = retry_q;
        restart  = 1'b0;
        case (state_q)
            ST_ASSERT: begin
                if (cnt_q == HOLD_LAST) state_nx = ST_PHY_WAIT;
            end
            ST_PHY_WAIT: begin
                // Lock wins over a timeout landing on the same cycle.
                if (phy_lock) begin
                    state_nx = ST_MAC_WAIT;
                end else if (cnt_q == LOCK_LAST) begin
                    retry_nx = retry_q + RETRY_W'(1);
                    state_nx = (retry_q == RETRY_LAST) ? ST_FAIL : ST_ASSERT;
                end
            end
            ST_MAC_WAIT: begin
                if (!phy_lock) begin
                    state_nx = ST_ASSERT;
                end else if (cnt_q == STAG_LAST) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.soft_reset_req) begin
                    retry_nx = '0;
`ifdef ETH_RST_DRAIN_EN
                    state_nx = ST_DRAIN;
`else
                    state_nx = ST_ASSERT;
`endif
                end else if (!phy_lock) begin
                    retry_nx = '0;
                    state_nx = ST_ASSERT;
                end
            end
`ifdef ETH_RST_DRAIN_EN
            ST_DRAIN: begin
                if (!phy_lock || bus.dma_idle || cnt_q == DRAIN_LAST) state_nx = ST_ASSERT;
            end
`endif
            ST_FAIL: begin
                state_nx = ST_FAIL;
            end
            default: begin
                state_nx = ST_ASSERT;
            end
        endcase
        // Outside RUN a soft reset always starts a fresh sequence, even from ASSERT.
        if (bus.soft_reset_req && state_q != ST_RUN) begin
            restart  = 1'b1;
            state_nx = ST_ASSERT;
            retry_nx = '0;
        end
    end

    assign cnt_clr = restart || (state_nx != state_q);

`ifndef ETH_RST_DRAIN_EN
    logic unused_drain;
    assign unused_drain = ^{bus.dma_idle, DRAIN_LAST};
`endif

    assign bus.phy_reset = out_q.phy;
    assign bus.mac_reset = out_q.mac;
    assign bus.dma_reset = out_q.dma;
    assign bus.rst_done  = out_q.done;
    assign bus.rst_fail  = out_q.fail;
    assign bus.retry_cnt = retry_q;

endmodule
